// File: rtl/race_control_multi_if.sv
// Draw bus between the race controller and the shared plot datapath.
// master: controller side (drives draw selects, plot, move, carSel; receives done flags)
// slave : datapath side
//   DoneDrawStart/BG/Car/Erase/Boom/Win  datapath done flags (level)
//   drawStartScreen/drawBG/drawCar/drawErase/drawBoom/drawWinScreen  draw selects
//   plot    VGA write enable
//   move    one-hot, 1 cycle: update position of car i
//   carSel  car targeted by draw/erase/boom
interface race_control_multi_if #(
  parameter int NUM_CARS = 2
);
  localparam int CAR_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

  logic                DoneDrawStart;
  logic                DoneDrawBG;
  logic                DoneDrawCar;
  logic                DoneDrawErase;
  logic                DoneDrawBoom;
  logic                DoneDrawWin;
  logic                drawStartScreen;
  logic                drawBG;
  logic                drawCar;
  logic                drawErase;
  logic                drawBoom;
  logic                drawWinScreen;
  logic                plot;
  logic [NUM_CARS-1:0] move;
  logic [CAR_W-1:0]    carSel;

  modport master (
    input  DoneDrawStart, DoneDrawBG, DoneDrawCar, DoneDrawErase, DoneDrawBoom, DoneDrawWin,
    output drawStartScreen, drawBG, drawCar, drawErase, drawBoom, drawWinScreen,
    output plot, move, carSel
  );

  modport slave (
    output DoneDrawStart, DoneDrawBG, DoneDrawCar, DoneDrawErase, DoneDrawBoom, DoneDrawWin,
    input  drawStartScreen, drawBG, drawCar, drawErase, drawBoom, drawWinScreen,
    input  plot, move, carSel
  );
endinterface

// File: rtl/race_control_multi.sv
// Top-level game FSM for an N-car race: sequences start/background/per-car
// erase-move-redraw/explosion/win draws, counts laps and declares the winner.
// Ports:
//   Clock, Resetn        clock, synchronous active-low reset
//   EnableOneFrame       1-cycle frame tick
//   start                race enable switch (level)
//   forward/left/right   per-car controls (level, synchronised)
//   lapPulse             1-cycle pulse: car i crossed the finish line
//   collision            level: car i off-track/hit
//   setResetSignals      strobe while in reset state
//   startRace            1-cycle strobe at race start
//   winner               winning car, valid while drawWinScreen
//   lapCount             packed per-car lap counters
//   draw_bus             draw selects / done flags / plot / move / carSel
module race_control_multi #(
  parameter int NUM_CARS = 2,
  parameter int NUM_LAPS = 3,
  localparam int CAR_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1,
  localparam int LAP_W = $clog2(NUM_LAPS + 1)
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      EnableOneFrame,
  input  logic                      start,
  input  logic [NUM_CARS-1:0]       forward,
  input  logic [NUM_CARS-1:0]       left,
  input  logic [NUM_CARS-1:0]       right,
  input  logic [NUM_CARS-1:0]       lapPulse,
  input  logic [NUM_CARS-1:0]       collision,
  output logic                      setResetSignals,
  output logic                      startRace,
  output logic [CAR_W-1:0]          winner,
  output logic [NUM_CARS*LAP_W-1:0] lapCount,
  race_control_multi_if.master      draw_bus
);

  typedef enum logic [3:0] {
    RESET_SIG, START_SCR, START_RACE, DRAW_BG, DRAW_CAR, IDLE,
    ERASE, MOVE, REDRAW, DRAW_BOOM, DRAW_WIN
  } state_t;

  state_t               state, state_n;
  logic [CAR_W-1:0]     car_sel, car_sel_n;
  logic [CAR_W-1:0]     winner_q, winner_n;
  logic [NUM_CARS-1:0]  req, req_n;
  logic [NUM_CARS-1:0]  steer_prev, steer_prev_n;
  logic [NUM_CARS-1:0]  steer, frame_req;
  logic [LAP_W-1:0]     laps [NUM_CARS];
  logic                 lap_clear, in_race;
  logic                 win_any;
  logic [CAR_W-1:0]     win_idx;

  function automatic logic [CAR_W-1:0] lowest(input logic [NUM_CARS-1:0] v);
    logic [CAR_W-1:0] r;
    r = '0;
    for (int unsigned i = NUM_CARS; i > 0; i--) begin
      if (v[i-1]) r = CAR_W'(i - 1);
    end
    return r;
  endfunction

  assign steer  = left | right;
  assign winner = winner_q;
  assign draw_bus.carSel = car_sel;

  // Ties resolve to the lowest index by scanning downwards.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int unsigned i = NUM_CARS; i > 0; i--) begin
      if (laps[i-1] == LAP_W'(NUM_LAPS)) begin
        win_any = 1'b1;
        win_idx = CAR_W'(i - 1);
      end
    end
  end

  always_comb begin
    lapCount = '0;
    for (int unsigned i = 0; i < NUM_CARS; i++) begin
      lapCount[i*LAP_W +: LAP_W] = laps[i];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= RESET_SIG;
      car_sel    <= '0;
      winner_q   <= '0;
      req        <= '0;
      steer_prev <= '0;
    end else begin
      state      <= state_n;
      car_sel    <= car_sel_n;
      winner_q   <= winner_n;
      req        <= req_n;
      steer_prev <= steer_prev_n;
    end
  end

  always_comb begin
    state_n      = state;
    car_sel_n    = car_sel;
    winner_n     = winner_q;
    req_n        = req;
    steer_prev_n = steer_prev;
    frame_req    = '0;
    lap_clear    = 1'b0;
    in_race      = 1'b0;

    setResetSignals          = 1'b0;
    startRace                = 1'b0;
    draw_bus.drawStartScreen = 1'b0;
    draw_bus.drawBG          = 1'b0;
    draw_bus.drawCar         = 1'b0;
    draw_bus.drawErase       = 1'b0;
    draw_bus.drawBoom        = 1'b0;
    draw_bus.drawWinScreen   = 1'b0;
    draw_bus.plot            = 1'b0;
    draw_bus.move            = '0;

    unique case (state)
      RESET_SIG: begin
        setResetSignals = 1'b1;
        state_n         = START_SCR;
      end
      START_SCR: begin
        draw_bus.drawStartScreen = 1'b1;
        draw_bus.plot            = 1'b1;
        if (draw_bus.DoneDrawStart && start) state_n = START_RACE;
      end
      START_RACE: begin
        startRace = 1'b1;
        lap_clear = 1'b1;
        state_n   = DRAW_BG;
      end
      DRAW_BG: begin
        in_race         = 1'b1;
        draw_bus.drawBG = 1'b1;
        draw_bus.plot   = 1'b1;
        if (draw_bus.DoneDrawBG) begin
          state_n   = DRAW_CAR;
          car_sel_n = '0;
        end
      end
      DRAW_CAR: begin
        in_race = 1'b1;
        if (!draw_bus.DoneDrawCar) begin
          draw_bus.drawCar = 1'b1;
          draw_bus.plot    = 1'b1;
        end else if (car_sel == CAR_W'(NUM_CARS - 1)) begin
          state_n = IDLE;
        end else begin
          car_sel_n = car_sel + 1'b1;
        end
      end
      IDLE: begin
        in_race = 1'b1;
        if (!start) begin
          state_n = RESET_SIG;
        end else if (win_any) begin
          state_n  = DRAW_WIN;
          winner_n = win_idx;
        end else if (|collision) begin
          state_n   = DRAW_BOOM;
          car_sel_n = lowest(collision);
        end else if (EnableOneFrame) begin
          // Steering history advances only on frames seen here, so a held
          // press yields one lateral step however many frames it spans.
          frame_req    = forward | (steer & ~steer_prev);
          steer_prev_n = steer;
          req_n        = frame_req;
          if (|frame_req) begin
            car_sel_n = lowest(frame_req);
            state_n   = ERASE;
          end
        end
      end
      ERASE: begin
        in_race = 1'b1;
        if (!draw_bus.DoneDrawErase) begin
          draw_bus.drawErase = 1'b1;
          draw_bus.plot      = 1'b1;
        end else begin
          state_n = MOVE;
        end
      end
      MOVE: begin
        in_race       = 1'b1;
        draw_bus.move = NUM_CARS'(1) << car_sel;
        // Retire the serviced bit so the lowest remaining bit is the next car.
        req_n         = req & ~(NUM_CARS'(1) << car_sel);
        state_n       = REDRAW;
      end
      REDRAW: begin
        in_race = 1'b1;
        if (!draw_bus.DoneDrawCar) begin
          draw_bus.drawCar = 1'b1;
          draw_bus.plot    = 1'b1;
        end else if (|req) begin
          car_sel_n = lowest(req);
          state_n   = ERASE;
        end else begin
          state_n = IDLE;
        end
      end
      DRAW_BOOM: begin
        in_race = 1'b1;
        if (!draw_bus.DoneDrawBoom) begin
          draw_bus.drawBoom = 1'b1;
          draw_bus.plot     = 1'b1;
        end
        if (!start) state_n = RESET_SIG;
      end
      DRAW_WIN: begin
        in_race                = 1'b1;
        draw_bus.drawWinScreen = 1'b1;
        draw_bus.plot          = 1'b1;
        if (!start) state_n = RESET_SIG;
      end
      default: state_n = RESET_SIG;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn || lap_clear) begin
      for (int unsigned i = 0; i < NUM_CARS; i++) laps[i] <= '0;
    end else if (in_race) begin
      for (int unsigned i = 0; i < NUM_CARS; i++) begin
        if (lapPulse[i] && laps[i] != LAP_W'(NUM_LAPS)) laps[i] <= laps[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_race_control_multi.sv
// Directed self-checking bench for race_control_multi (2 cars, 3 laps).
module tb_race_control_multi;

  logic       Clock = 1'b0;
  logic       Resetn, EnableOneFrame, start;
  logic [1:0] forward, left, right, lapPulse, collision;
  logic       setResetSignals, startRace;
  logic [0:0] winner;
  logic [3:0] lapCount;
  int         n_vec = 0;
  int         n_err = 0;
  int         mv1_cnt = 0;
  int         mv1_base;

  race_control_multi_if #(.NUM_CARS(2)) bus ();

  race_control_multi #(.NUM_CARS(2), .NUM_LAPS(3)) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .EnableOneFrame (EnableOneFrame),
    .start          (start),
    .forward        (forward),
    .left           (left),
    .right          (right),
    .lapPulse       (lapPulse),
    .collision      (collision),
    .setResetSignals(setResetSignals),
    .startRace      (startRace),
    .winner         (winner),
    .lapCount       (lapCount),
    .draw_bus       (bus)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (bus.move[1]) mv1_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Entered in START_SCR; leaves the FSM in IDLE.
  task automatic startup();
    bus.DoneDrawStart = 1'b1;
    start = 1'b1;
    step();
    chk("start_race", {31'b0, startRace}, 1);
    bus.DoneDrawStart = 1'b0;
    step();
    chk("bg_sel", {31'b0, bus.drawBG}, 1);
    chk("bg_plot", {31'b0, bus.plot}, 1);
    chk("start_race_1cyc", {31'b0, startRace}, 0);
    chk("laps_cleared", {28'b0, lapCount}, 0);
    bus.DoneDrawBG = 1'b1;
    step();
    bus.DoneDrawBG = 1'b0;
    #1;
    chk("car0_draw", {31'b0, bus.drawCar}, 1);
    chk("car0_sel", {31'b0, bus.carSel}, 0);
    bus.DoneDrawCar = 1'b1;
    step();
    chk("car1_sel", {31'b0, bus.carSel}, 1);
    bus.DoneDrawCar = 1'b0;
    #1;
    chk("car1_draw", {31'b0, bus.drawCar}, 1);
    bus.DoneDrawCar = 1'b1;
    step();
    bus.DoneDrawCar = 1'b0;
    #1;
    chk("idle_quiet", {31'b0, bus.plot}, 0);
  endtask

  // Entered in ERASE for the given car; erase is held 4 cycles before done.
  task automatic service(input int car);
    chk("erase_sel", {31'b0, bus.carSel}, car);
    chk("erase_on", {31'b0, bus.drawErase}, 1);
    step(3);
    chk("erase_plot_held", {31'b0, bus.plot}, 1);
    bus.DoneDrawErase = 1'b1;
    #1;
    chk("erase_done_plot", {31'b0, bus.plot}, 0);
    step();
    bus.DoneDrawErase = 1'b0;
    chk("move_pulse", {30'b0, bus.move}, 32'(1 << car));
    step();
    chk("move_1cyc", {30'b0, bus.move}, 0);
    chk("redraw_on", {31'b0, bus.drawCar}, 1);
    chk("redraw_sel", {31'b0, bus.carSel}, car);
    bus.DoneDrawCar = 1'b1;
    step();
    bus.DoneDrawCar = 1'b0;
    #1;
  endtask

  task automatic frame();
    EnableOneFrame = 1'b1;
    step();
    EnableOneFrame = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0; EnableOneFrame = 1'b0; start = 1'b0;
    forward = '0; left = '0; right = '0; lapPulse = '0; collision = '0;
    bus.DoneDrawStart = 1'b0; bus.DoneDrawBG = 1'b0; bus.DoneDrawCar = 1'b0;
    bus.DoneDrawErase = 1'b0; bus.DoneDrawBoom = 1'b0; bus.DoneDrawWin = 1'b0;
    step(2);
    chk("rst_setreset", {31'b0, setResetSignals}, 1);
    chk("rst_plot", {31'b0, bus.plot}, 0);
    chk("rst_startscr", {31'b0, bus.drawStartScreen}, 0);
    chk("rst_laps", {28'b0, lapCount}, 0);
    chk("rst_winner", {31'b0, winner}, 0);
    chk("rst_carsel", {31'b0, bus.carSel}, 0);

    // 1: start screen then race start sequence
    Resetn = 1'b1;
    step();
    chk("startscr_sel", {31'b0, bus.drawStartScreen}, 1);
    chk("startscr_plot", {31'b0, bus.plot}, 1);
    startup();

    // 2: both cars forward on one frame
    forward = 2'b11;
    frame();
    forward = 2'b00;
    service(0);
    service(1);
    chk("after_loop_idle", {31'b0, bus.drawErase}, 0);

    // 3: held steering gives one step per press
    mv1_base = mv1_cnt;
    left = 2'b10;
    frame();
    service(1);
    for (int f = 0; f < 4; f++) begin
      frame();
      chk("held_no_erase", {31'b0, bus.drawErase}, 0);
      step(2);
    end
    chk("held_one_move", 32'(mv1_cnt - mv1_base), 1);
    left = 2'b00;
    frame();
    chk("release_no_erase", {31'b0, bus.drawErase}, 0);
    left = 2'b10;
    frame();
    service(1);
    left = 2'b00;
    chk("repress_two_moves", 32'(mv1_cnt - mv1_base), 2);

    // 4: simultaneous finish, tie to car 0, saturation, exit on start=0
    lapPulse = 2'b11;
    step(3);
    lapPulse = 2'b00;
    chk("laps_three_each", {28'b0, lapCount}, 4'hF);
    step();
    chk("win_sel", {31'b0, bus.drawWinScreen}, 1);
    chk("win_winner", {31'b0, winner}, 0);
    bus.DoneDrawWin = 1'b1;
    lapPulse = 2'b11;
    step();
    lapPulse = 2'b00;
    chk("win_hold_plot", {31'b0, bus.plot}, 1);
    chk("win_hold_sel", {31'b0, bus.drawWinScreen}, 1);
    chk("laps_saturate", {28'b0, lapCount}, 4'hF);
    bus.DoneDrawWin = 1'b0;
    start = 1'b0;
    step();
    chk("win_exit_reset", {31'b0, setResetSignals}, 1);
    step();
    startup();

    // 5: collision on car 1
    collision = 2'b10;
    step();
    chk("boom_sel", {31'b0, bus.drawBoom}, 1);
    chk("boom_carsel", {31'b0, bus.carSel}, 1);
    step(2);
    chk("boom_plot", {31'b0, bus.plot}, 1);
    bus.DoneDrawBoom = 1'b1;
    #1;
    chk("boom_done_plot", {31'b0, bus.plot}, 0);
    step(2);
    chk("boom_hold", {31'b0, setResetSignals}, 0);
    chk("boom_hold_sel", {31'b0, bus.carSel}, 1);
    collision = 2'b00;
    start = 1'b0;
    step();
    bus.DoneDrawBoom = 1'b0;
    chk("boom_exit_reset", {31'b0, setResetSignals}, 1);
    step();
    startup();

    // 6: reset in the middle of an erase
    lapPulse = 2'b01;
    step();
    lapPulse = 2'b00;
    chk("lap_one", {28'b0, lapCount}, 4'h1);
    forward = 2'b01;
    frame();
    forward = 2'b00;
    chk("pre_rst_erase", {31'b0, bus.drawErase}, 1);
    Resetn = 1'b0;
    step();
    chk("midrst_setreset", {31'b0, setResetSignals}, 1);
    chk("midrst_plot", {31'b0, bus.plot}, 0);
    chk("midrst_erase", {31'b0, bus.drawErase}, 0);
    chk("midrst_laps", {28'b0, lapCount}, 0);
    Resetn = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
